// File: rtl/wq2_rptr_status_pkg.sv
// Shared async-FIFO package: pointer type, Gray/binary conversions and the
// default almost-full threshold for the write-side status block.
package wq2_rptr_status_pkg;

  localparam int FIFO_ADDR        = 4;
  localparam int AFULL_THRESH_DEF = (1 << FIFO_ADDR) - 2;

  typedef logic [FIFO_ADDR:0] ptr_t;

  // Width-generic: callers zero-extend into 32 bits and cast the result back.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/wq2_rptr_status_sync_ff_chain.sv
// Width-generic multi-flop synchronizer; plain flop chain with no logic
// between stages. Shared by both FIFO clock domains.
module sync_ff_chain #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/wq2_rptr_status.sv
// Write-domain read-pointer receiver: syncs the Gray read pointer, converts it
// to binary and registers fill level / almost-full. Optional WQ2_RPTR_LEVEL_CHECK_EN.
module wq2_rptr_status
  import wq2_rptr_status_pkg::*;
#(
  parameter int ADDR         = FIFO_ADDR,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic [ADDR:0] rptr,
  input  logic [ADDR:0] wbin,
  output logic [ADDR:0] wq2_rptr,
  output logic [ADDR:0] wq2_rbin,
  output logic [ADDR:0] wlevel,
  output logic          walmost_full,
  output logic          werr
);

  localparam logic [ADDR:0] LVL_FULL  = {1'b1, {ADDR{1'b0}}};
  localparam logic [ADDR:0] LVL_THR   = (ADDR+1)'(AFULL_THRESH);

  logic [ADDR:0] w_q2_rptr;
  logic [ADDR:0] w_rbin_nxt;
  logic [ADDR:0] w_diff;
  logic          w_diff_bad;
  logic [ADDR:0] w_level_nxt;
  logic          w_afull_nxt;

  logic [ADDR:0] r_rbin;
  logic [ADDR:0] r_level;
  logic          r_afull;

  sync_ff_chain #(
    .WIDTH  (ADDR+1),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (wclk),
    .rst_n (wrst_n),
    .i_d   (rptr),
    .o_q   (w_q2_rptr)
  );

  assign w_rbin_nxt = (ADDR+1)'(gray2bin(32'(w_q2_rptr)));

  // Modular subtraction; a wrapped pointer pair lands exactly on LVL_FULL.
  assign w_diff      = wbin - r_rbin;
  assign w_diff_bad  = (w_diff > LVL_FULL);
  assign w_level_nxt = w_diff_bad ? LVL_FULL : w_diff;
  assign w_afull_nxt = (w_level_nxt >= LVL_THR);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_rbin  <= '0;
      r_level <= '0;
      r_afull <= 1'b0;
    end else begin
      r_rbin  <= w_rbin_nxt;
      r_level <= w_level_nxt;
      r_afull <= w_afull_nxt;
    end
  end

`ifdef WQ2_RPTR_LEVEL_CHECK_EN
  logic r_err;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) r_err <= 1'b0;
    else if (w_diff_bad) r_err <= 1'b1;
  end

  assign werr = r_err;
`else
  assign werr = 1'b0;
`endif

  assign wq2_rptr     = w_q2_rptr;
  assign wq2_rbin     = r_rbin;
  assign wlevel       = r_level;
  assign walmost_full = r_afull;

endmodule
